arp_reply_scheduler: RTL

//  Sequences the ARP receive parser and turns each valid ARP request for this board into a
//  28-byte ARP reply payload. The payload goes to the shared Ethernet TX path through a
//  req/grant arbiter handshake. Sits between the RX frame demux (ARP byte stream), the
//  arp_parser instance it controls via parser_sclr, and the TX arbiter.

---
 rtl/eth_pkg.sv | 26 ++
 rtl/arp_reply_mux.sv | 49 ++++
 rtl/arp_reply_scheduler.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and the ARP reply scheduler state encoding.
package eth_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;

  localparam int unsigned ARP_LEN = 28;

  // Byte offsets of the address fields inside the ARP payload
  localparam logic [4:0] ARP_OFF_SHA  = 5'd8;
  localparam logic [4:0] ARP_OFF_SPA  = 5'd14;
  localparam logic [4:0] ARP_OFF_THA  = 5'd18;
  localparam logic [4:0] ARP_OFF_TPA  = 5'd24;
  localparam logic [4:0] ARP_LAST_IDX = 5'(ARP_LEN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StSend
  } arp_state_e;

endpackage

// File: rtl/arp_reply_mux.sv
// Combinational byte selector for the 28-byte ARP reply payload.
module arp_reply_mux
  import eth_pkg::*;
(
  input  logic [4:0]  idx_i,
  input  logic [47:0] my_mac_i,
  input  logic [31:0] my_ip_i,
  input  logic [47:0] pc_mac_i,
  input  logic [31:0] pc_ip_i,
  output logic [7:0]  data_o
);

  logic [63:0] hdr;
  logic [63:0] hdr_sh;
  logic [47:0] mac_sh;
  logic [31:0] ip_sh;
  logic [4:0]  off;

  assign hdr = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN_ETH, ARP_PLEN_IPV4, ARP_OPER_REPLY};

  // Pick the field that owns idx, then shift the wanted byte (MSB first) to the top
  always_comb begin
    data_o = 8'h00;
    off    = '0;
    mac_sh = '0;
    ip_sh  = '0;
    hdr_sh = hdr << {idx_i, 3'b000};
    if (idx_i < ARP_OFF_SHA) begin
      data_o = hdr_sh[63:56];
    end else if (idx_i < ARP_OFF_SPA) begin
      off    = idx_i - ARP_OFF_SHA;
      mac_sh = my_mac_i << {off, 3'b000};
      data_o = mac_sh[47:40];
    end else if (idx_i < ARP_OFF_THA) begin
      off    = idx_i - ARP_OFF_SPA;
      ip_sh  = my_ip_i << {off, 3'b000};
      data_o = ip_sh[31:24];
    end else if (idx_i < ARP_OFF_TPA) begin
      off    = idx_i - ARP_OFF_THA;
      mac_sh = pc_mac_i << {off, 3'b000};
      data_o = mac_sh[47:40];
    end else if (idx_i <= ARP_LAST_IDX) begin
      off    = idx_i - ARP_OFF_TPA;
      ip_sh  = pc_ip_i << {off, 3'b000};
      data_o = ip_sh[31:24];
    end
  end

endmodule

// File: rtl/arp_reply_scheduler.sv
// Turns qualified ARP requests for this board into 28-byte replies on the shared TX path.
module arp_reply_scheduler
  import eth_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [47:0]      my_mac,
  input  logic [31:0]      my_ip,
  input  logic             rx_data_en,
  input  logic [7:0]       rx_data,
  output logic             parser_sclr,
  input  logic [31:0]      pc_ip,
  input  logic [31:0]      board_ip,
  input  logic             parser_dataen,
  output logic             tx_req,
  input  logic             tx_grant,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_last,
  output logic             busy,
  output logic [CNT_W-1:0] reply_count,
  output logic [CNT_W-1:0] drop_count
);

  // Receive-side capture
  logic [4:0]  rc_q, rc_d;
  logic [15:0] htype_q, htype_d, ptype_q, ptype_d, oper_q, oper_d;
  logic [7:0]  hlen_q, hlen_d, plen_q, plen_d;
  logic [47:0] sha_q, sha_d;
  logic        dataen_q;
  logic        sclr_q;

  // Reply FSM and buffer
  arp_state_e       state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic             tx_req_q, tx_req_d, tx_valid_q, tx_valid_d;
  logic [47:0]      buf_mac_q, buf_mac_d;
  logic [31:0]      buf_ip_q, buf_ip_d;
  logic [CNT_W-1:0] reply_q, reply_d, drop_q, drop_d;

  logic       req_edge, fields_ok, req_ok, accept;
  logic [7:0] mux_data;

  // Header fields are complete long before the parser raises dataen at the end of the payload
  assign req_edge  = parser_dataen & ~dataen_q;
  assign fields_ok = (htype_q == ARP_HTYPE_ETH) && (ptype_q == ARP_PTYPE_IPV4) &&
                     (hlen_q == ARP_HLEN_ETH) && (plen_q == ARP_PLEN_IPV4) &&
                     (oper_q == ARP_OPER_REQ);
  assign req_ok    = req_edge && enable && fields_ok && (board_ip == my_ip);
  assign accept    = tx_valid_q & tx_ready;

  // Byte counter aligned with the parser and header/SHA capture
  always_comb begin
    rc_d    = rc_q;
    htype_d = htype_q;
    ptype_d = ptype_q;
    hlen_d  = hlen_q;
    plen_d  = plen_q;
    oper_d  = oper_q;
    sha_d   = sha_q;
    if (!rx_data_en) begin
      rc_d = '0;
    end else begin
      // Saturate so padded frames never wrap back onto the header offsets
      if (rc_q != 5'h1f) rc_d = rc_q + 5'd1;
      case (rc_q)
        5'd0:    htype_d[15:8] = rx_data;
        5'd1:    htype_d[7:0]  = rx_data;
        5'd2:    ptype_d[15:8] = rx_data;
        5'd3:    ptype_d[7:0]  = rx_data;
        5'd4:    hlen_d        = rx_data;
        5'd5:    plen_d        = rx_data;
        5'd6:    oper_d[15:8]  = rx_data;
        5'd7:    oper_d[7:0]   = rx_data;
        5'd8:    sha_d[47:40]  = rx_data;
        5'd9:    sha_d[39:32]  = rx_data;
        5'd10:   sha_d[31:24]  = rx_data;
        5'd11:   sha_d[23:16]  = rx_data;
        5'd12:   sha_d[15:8]   = rx_data;
        5'd13:   sha_d[7:0]    = rx_data;
        default: ;
      endcase
    end
  end

  // Reply FSM next state, one-deep reply buffer and saturating counters
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_req_d   = tx_req_q;
    tx_valid_d = tx_valid_q;
    buf_mac_d  = buf_mac_q;
    buf_ip_d   = buf_ip_q;
    reply_d    = reply_q;
    drop_d     = drop_q;
    unique case (state_q)
      StIdle: begin
        if (req_ok) begin
          buf_mac_d = sha_q;
          buf_ip_d  = pc_ip;
          tx_req_d  = 1'b1;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (tx_grant) begin
          idx_d      = '0;
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (accept && (idx_q == ARP_LAST_IDX)) begin
          idx_d      = '0;
          tx_req_d   = 1'b0;
          tx_valid_d = 1'b0;
          state_d    = StIdle;
          if (reply_q != '1) reply_d = reply_q + CNT_W'(1);
        end else begin
          if (accept) idx_d = idx_q + 5'd1;
          // A lost grant stalls the stream until the arbiter gives it back
          tx_valid_d = tx_grant;
        end
      end
      default: state_d = StIdle;
    endcase
    if (req_ok && (state_q != StIdle) && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
  end

  // All state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rc_q       <= '0;
      htype_q    <= '0;
      ptype_q    <= '0;
      hlen_q     <= '0;
      plen_q     <= '0;
      oper_q     <= '0;
      sha_q      <= '0;
      dataen_q   <= 1'b0;
      sclr_q     <= 1'b1;
      state_q    <= StIdle;
      idx_q      <= '0;
      tx_req_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      buf_mac_q  <= '0;
      buf_ip_q   <= '0;
      reply_q    <= '0;
      drop_q     <= '0;
    end else begin
      rc_q       <= rc_d;
      htype_q    <= htype_d;
      ptype_q    <= ptype_d;
      hlen_q     <= hlen_d;
      plen_q     <= plen_d;
      oper_q     <= oper_d;
      sha_q      <= sha_d;
      dataen_q   <= parser_dataen;
      sclr_q     <= ~enable;
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_req_q   <= tx_req_d;
      tx_valid_q <= tx_valid_d;
      buf_mac_q  <= buf_mac_d;
      buf_ip_q   <= buf_ip_d;
      reply_q    <= reply_d;
      drop_q     <= drop_d;
    end
  end

  arp_reply_mux u_mux (
    .idx_i    (idx_q),
    .my_mac_i (my_mac),
    .my_ip_i  (my_ip),
    .pc_mac_i (buf_mac_q),
    .pc_ip_i  (buf_ip_q),
    .data_o   (mux_data)
  );

  assign parser_sclr = sclr_q;
  assign tx_req      = tx_req_q;
  assign tx_valid    = tx_valid_q;
  assign tx_last     = tx_valid_q && (idx_q == ARP_LAST_IDX);
  assign tx_data     = tx_valid_q ? mux_data : 8'h00;
  assign busy        = (state_q != StIdle);
  assign reply_count = reply_q;
  assign drop_count  = drop_q;

endmodule
